// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file -- machine-mode CSR register file for the single-cycle RV32 core.
//
// Holds mstatus (0x300), mtvec (0x305), mepc (0x341) and mcause (0x342).
// Optional build macro MSCRATCH_EN adds mscratch (0x340), which is reachable
// only through the generic read/write ports.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_ren, i_raddr     combinational read port -> o_rdata (0 if disabled
//                      or the address is unmapped)
//   i_wen, i_waddr,    generic registered write port (full-width, no masking)
//   i_wdata
//   i_mepc_*, i_mcause_*, i_mstatus_*
//                      trap-side write ports; each beats a generic write to
//                      the same register in the same cycle
//   o_mtvec, o_mstatus, o_mepc
//                      direct register outputs to the PC unit
//
// Interface timing: there is no valid/ready handshake. Every enable is a
// single-cycle qualifier already validated upstream; a write enable that is
// high at a rising edge commits that edge, and reads are purely
// combinational with no bypass of a write landing on the same edge.
// ---------------------------------------------------------------------------
module csr_file #(
  parameter int CPU_WIDTH = 32,
  parameter int CSR_ADDRW = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ren,
  input  logic [CSR_ADDRW-1:0] i_raddr,
  output logic [CPU_WIDTH-1:0] o_rdata,
  input  logic                 i_wen,
  input  logic [CSR_ADDRW-1:0] i_waddr,
  input  logic [CPU_WIDTH-1:0] i_wdata,
  input  logic                 i_mepc_wen,
  input  logic [CPU_WIDTH-1:0] i_mepc_wdata,
  input  logic                 i_mcause_wen,
  input  logic [CPU_WIDTH-1:0] i_mcause_wdata,
  input  logic                 i_mstatus_wen,
  input  logic [CPU_WIDTH-1:0] i_mstatus_wdata,
  output logic [CPU_WIDTH-1:0] o_mtvec,
  output logic [CPU_WIDTH-1:0] o_mstatus,
  output logic [CPU_WIDTH-1:0] o_mepc
);

  localparam logic [CSR_ADDRW-1:0] ADDR_MSTATUS  = CSR_ADDRW'(12'h300);
  localparam logic [CSR_ADDRW-1:0] ADDR_MTVEC    = CSR_ADDRW'(12'h305);
  localparam logic [CSR_ADDRW-1:0] ADDR_MSCRATCH = CSR_ADDRW'(12'h340);
  localparam logic [CSR_ADDRW-1:0] ADDR_MEPC     = CSR_ADDRW'(12'h341);
  localparam logic [CSR_ADDRW-1:0] ADDR_MCAUSE   = CSR_ADDRW'(12'h342);

  // MPP = 2'b11: the core only ever runs in machine mode.
  localparam logic [CPU_WIDTH-1:0] MSTATUS_RST = CPU_WIDTH'(32'h0000_1800);

  logic [CPU_WIDTH-1:0] mstatus_q;
  logic [CPU_WIDTH-1:0] mtvec_q;
  logic [CPU_WIDTH-1:0] mepc_q;
  logic [CPU_WIDTH-1:0] mcause_q;

  // Per-register generic write hits.
  logic gen_mstatus;
  logic gen_mtvec;
  logic gen_mepc;
  logic gen_mcause;

  assign gen_mstatus = i_wen && (i_waddr == ADDR_MSTATUS);
  assign gen_mtvec   = i_wen && (i_waddr == ADDR_MTVEC);
  assign gen_mepc    = i_wen && (i_waddr == ADDR_MEPC);
  assign gen_mcause  = i_wen && (i_waddr == ADDR_MCAUSE);

  // Trap writes are checked first so they override a colliding generic write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      if (i_mstatus_wen)    mstatus_q <= i_mstatus_wdata;
      else if (gen_mstatus) mstatus_q <= i_wdata;

      if (gen_mtvec)        mtvec_q   <= i_wdata;

      if (i_mepc_wen)       mepc_q    <= i_mepc_wdata;
      else if (gen_mepc)    mepc_q    <= i_wdata;

      if (i_mcause_wen)     mcause_q  <= i_mcause_wdata;
      else if (gen_mcause)  mcause_q  <= i_wdata;
    end
  end

`ifdef MSCRATCH_EN
  logic [CPU_WIDTH-1:0] mscratch_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mscratch_q <= '0;
    end else if (i_wen && (i_waddr == ADDR_MSCRATCH)) begin
      mscratch_q <= i_wdata;
    end
  end
`endif

  // Read mux shows the pre-edge value even when a write hits the same CSR.
  always_comb begin
    o_rdata = '0;
    if (i_ren) begin
      case (i_raddr)
        ADDR_MSTATUS:  o_rdata = mstatus_q;
        ADDR_MTVEC:    o_rdata = mtvec_q;
        ADDR_MEPC:     o_rdata = mepc_q;
        ADDR_MCAUSE:   o_rdata = mcause_q;
`ifdef MSCRATCH_EN
        ADDR_MSCRATCH: o_rdata = mscratch_q;
`endif
        default:       o_rdata = '0;
      endcase
    end
  end

  assign o_mtvec   = mtvec_q;
  assign o_mstatus = mstatus_q;
  assign o_mepc    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file -- directed, table-driven bench for csr_file.
// Each table row is one clock cycle: inputs are driven after the falling
// edge, o_rdata is compared before the next rising edge (pre-edge value),
// and the direct outputs are compared just after that rising edge.
// ---------------------------------------------------------------------------
module tb_csr_file;

  localparam int W  = 32;
  localparam int AW = 12;
  localparam int NV = 23;

`ifdef MSCRATCH_EN
  localparam logic [W-1:0] SCRATCH_RB = 32'hA5A5_A5A5;
`else
  localparam logic [W-1:0] SCRATCH_RB = 32'h0000_0000;
`endif

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_ren = 1'b0;
  logic [AW-1:0] i_raddr = '0;
  logic [W-1:0]  o_rdata;
  logic          i_wen = 1'b0;
  logic [AW-1:0] i_waddr = '0;
  logic [W-1:0]  i_wdata = '0;
  logic          i_mepc_wen = 1'b0;
  logic [W-1:0]  i_mepc_wdata = '0;
  logic          i_mcause_wen = 1'b0;
  logic [W-1:0]  i_mcause_wdata = '0;
  logic          i_mstatus_wen = 1'b0;
  logic [W-1:0]  i_mstatus_wdata = '0;
  logic [W-1:0]  o_mtvec;
  logic [W-1:0]  o_mstatus;
  logic [W-1:0]  o_mepc;

  always #5 i_clk = ~i_clk;

  csr_file #(.CPU_WIDTH(W), .CSR_ADDRW(AW)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_ren           (i_ren),
    .i_raddr         (i_raddr),
    .o_rdata         (o_rdata),
    .i_wen           (i_wen),
    .i_waddr         (i_waddr),
    .i_wdata         (i_wdata),
    .i_mepc_wen      (i_mepc_wen),
    .i_mepc_wdata    (i_mepc_wdata),
    .i_mcause_wen    (i_mcause_wen),
    .i_mcause_wdata  (i_mcause_wdata),
    .i_mstatus_wen   (i_mstatus_wen),
    .i_mstatus_wdata (i_mstatus_wdata),
    .o_mtvec         (o_mtvec),
    .o_mstatus       (o_mstatus),
    .o_mepc          (o_mepc)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          pw;
    logic [W-1:0]  pd;
    logic          cw;
    logic [W-1:0]  cd;
    logic          sw;
    logic [W-1:0]  sd;
    logic [W-1:0]  e_rdata;
    logic [W-1:0]  e_mtvec;
    logic [W-1:0]  e_mstatus;
    logic [W-1:0]  e_mepc;
  } vec_t;

  vec_t vec [NV];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    i_rst           = v.rst;
    i_ren           = v.ren;
    i_raddr         = v.raddr;
    i_wen           = v.wen;
    i_waddr         = v.waddr;
    i_wdata         = v.wdata;
    i_mepc_wen      = v.pw;
    i_mepc_wdata    = v.pd;
    i_mcause_wen    = v.cw;
    i_mcause_wdata  = v.cd;
    i_mstatus_wen   = v.sw;
    i_mstatus_wdata = v.sd;
  endtask

  task automatic idle();
    vec_t z;
    z = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0,
          1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    drive(z);
  endtask

  initial begin
    //          rst  ren  raddr    wen  waddr    wdata          pw   pd             cw   cd            sw   sd             e_rdata        e_mtvec        e_mstatus      e_mepc
    vec[0]  = '{1'b1,1'b0,12'h300, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h0,         32'h1800,      32'h0};
    vec[1]  = '{1'b1,1'b0,12'h300, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h0,         32'h1800,      32'h0};
    vec[2]  = '{1'b0,1'b1,12'h342, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h0,         32'h1800,      32'h0};
    vec[3]  = '{1'b0,1'b1,12'h305, 1'b1,12'h305, 32'h80000100,  1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h80000100,  32'h1800,      32'h0};
    vec[4]  = '{1'b0,1'b1,12'h305, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h80000100,  32'h80000100,  32'h1800,      32'h0};
    vec[5]  = '{1'b0,1'b1,12'h341, 1'b0,12'h000, 32'h0,         1'b1,32'h80000010,  1'b1,32'hB,        1'b1,32'h1880,      32'h0,         32'h80000100,  32'h1880,      32'h80000010};
    vec[6]  = '{1'b0,1'b1,12'h342, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'hB,         32'h80000100,  32'h1880,      32'h80000010};
    vec[7]  = '{1'b0,1'b1,12'h300, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h1880,      32'h80000100,  32'h1880,      32'h80000010};
    vec[8]  = '{1'b0,1'b1,12'h341, 1'b1,12'h341, 32'hDEADBEEF,  1'b1,32'h80000020,  1'b0,32'h0,        1'b0,32'h0,         32'h80000010,  32'h80000100,  32'h1880,      32'h80000020};
    vec[9]  = '{1'b0,1'b1,12'h341, 1'b1,12'h305, 32'h12345678,  1'b1,32'h80000030,  1'b0,32'h0,        1'b0,32'h0,         32'h80000020,  32'h12345678,  32'h1880,      32'h80000030};
    vec[10] = '{1'b0,1'b1,12'h7C0, 1'b1,12'h7C0, 32'hFFFFFFFF,  1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h12345678,  32'h1880,      32'h80000030};
    vec[11] = '{1'b0,1'b1,12'h342, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'hB,         32'h12345678,  32'h1880,      32'h80000030};
    vec[12] = '{1'b0,1'b0,12'h300, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h12345678,  32'h1880,      32'h80000030};
    vec[13] = '{1'b0,1'b1,12'h342, 1'b1,12'h342, 32'h7,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'hB,         32'h12345678,  32'h1880,      32'h80000030};
    vec[14] = '{1'b0,1'b1,12'h342, 1'b1,12'h300, 32'hABCD,      1'b0,32'h0,         1'b1,32'h1,        1'b0,32'h0,         32'h7,         32'h12345678,  32'hABCD,      32'h80000030};
    vec[15] = '{1'b0,1'b1,12'h342, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h1,         32'h12345678,  32'hABCD,      32'h80000030};
    vec[16] = '{1'b0,1'b1,12'h300, 1'b1,12'h300, 32'hFFFFFFFF,  1'b0,32'h0,         1'b0,32'h0,        1'b1,32'h88,        32'hABCD,      32'h12345678,  32'h88,        32'h80000030};
    vec[17] = '{1'b0,1'b1,12'h340, 1'b1,12'h340, 32'hA5A5A5A5,  1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h12345678,  32'h88,        32'h80000030};
    vec[18] = '{1'b0,1'b1,12'h340, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         SCRATCH_RB,    32'h12345678,  32'h88,        32'h80000030};
    vec[19] = '{1'b1,1'b1,12'h300, 1'b1,12'h305, 32'hFFFF,      1'b1,32'h1,         1'b0,32'h0,        1'b0,32'h0,         32'h88,        32'h0,         32'h1800,      32'h0};
    vec[20] = '{1'b0,1'b1,12'h342, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h0,         32'h1800,      32'h0};
    vec[21] = '{1'b0,1'b1,12'h340, 1'b0,12'h000, 32'h0,         1'b0,32'h0,         1'b0,32'h0,        1'b0,32'h0,         32'h0,         32'h0,         32'h1800,      32'h0};
    vec[22] = '{1'b0,1'b1,12'h341, 1'b1,12'h305, 32'h200,       1'b1,32'h100,       1'b0,32'h0,        1'b1,32'h8,         32'h0,         32'h200,       32'h8,         32'h100};

    // ---------------- table pass ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge i_clk);
      drive(vec[i]);
      #1;
      check($sformatf("v%0d rdata", i), o_rdata, vec[i].e_rdata);
      @(posedge i_clk);
      #1;
      check($sformatf("v%0d mtvec", i), o_mtvec, vec[i].e_mtvec);
      check($sformatf("v%0d mstatus", i), o_mstatus, vec[i].e_mstatus);
      check($sformatf("v%0d mepc", i), o_mepc, vec[i].e_mepc);
    end

    // ---------------- hold with all enables low ----------------
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h100);
    @(negedge i_clk);
    idle();
    for (int c = 0; c < 16; c++) begin
      @(posedge i_clk);
      #1;
      check($sformatf("hold%0d mtvec", c), o_mtvec, exp_q[0]);
      check($sformatf("hold%0d mstatus", c), o_mstatus, exp_q[1]);
      check($sformatf("hold%0d mepc", c), o_mepc, exp_q[2]);
    end
    exp_q.delete();

    // ---------------- back-to-back generic writes to mepc/mcause ----------------
    @(negedge i_clk);
    i_wen = 1'b1; i_waddr = 12'h341; i_wdata = 32'hCAFE0001;
    exp_q.push_back(32'hCAFE0001);
    @(negedge i_clk);
    i_waddr = 12'h342; i_wdata = 32'h0000000B;
    i_ren = 1'b1; i_raddr = 12'h341;
    #1;
    check("b2b mepc rdata", o_rdata, exp_q.pop_front());
    exp_q.push_back(32'h0000000B);
    @(negedge i_clk);
    i_wen = 1'b0; i_raddr = 12'h342;
    #1;
    check("b2b mcause rdata", o_rdata, exp_q.pop_front());
    check("b2b mepc direct", o_mepc, 32'hCAFE0001);

    @(negedge i_clk);
    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file for the single-cycle RV32 NPC core.
- Holds mstatus, mtvec, mepc and mcause.
- Provides:
  - one combinational read port, used by CSR instructions (csrrw/csrrs and variants) through the decoder and execute unit;
  - one generic registered write port, driven by the execute result;
  - dedicated trap-side write ports for ecall and mret;
  - direct outputs of mtvec, mstatus and mepc to the PC unit.

Parameters:
- CPU_WIDTH, 32, data width of every CSR and data port.
- CSR_ADDRW, 12, CSR address width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_ren  in  1  read enable.
- i_raddr  in  CSR_ADDRW  read address.
- o_rdata  out  CPU_WIDTH  read data.
- i_wen  in  1  generic write enable.
- i_waddr  in  CSR_ADDRW  generic write address.
- i_wdata  in  CPU_WIDTH  generic write data.
- i_mepc_wen  in  1  trap write enable for mepc.
- i_mepc_wdata  in  CPU_WIDTH  trap write data for mepc (faulting PC).
- i_mcause_wen  in  1  trap write enable for mcause.
- i_mcause_wdata  in  CPU_WIDTH  trap write data for mcause (0x0000000B for ecall from M-mode).
- i_mstatus_wen  in  1  trap write enable for mstatus.
- i_mstatus_wdata  in  CPU_WIDTH  trap write data for mstatus.
- o_mtvec  out  CPU_WIDTH  current mtvec.
- o_mstatus  out  CPU_WIDTH  current mstatus.
- o_mepc  out  CPU_WIDTH  current mepc.

Behaviour:
- Address map:
  - mstatus 0x300
  - mtvec 0x305
  - mepc 0x341
  - mcause 0x342
- Reset: while i_rst=1 at a rising edge:
  - mstatus <= 0x00001800 (MPP=11);
  - mtvec, mepc, mcause <= 0;
  - all write requests that cycle are ignored.
- Read port:
  - Purely combinational.
  - o_rdata = selected CSR when i_ren=1 and i_raddr is mapped.
  - o_rdata = 0 when i_ren=0 or the address is unmapped.
- Read-during-write: o_rdata shows the pre-edge value; no bypass. The new value is visible the cycle after the edge.
- Generic write:
  - When i_wen=1, the CSR at i_waddr is loaded with the full i_wdata at the rising edge.
  - Unmapped addresses are ignored with no side effect. No field masking; all CPU_WIDTH bits are writable.
- Trap writes:
  - i_mepc_wen, i_mcause_wen and i_mstatus_wen each load their register at the rising edge.
  - They are independent, and may assert together with each other.
- Priority: when a trap write and a generic write target the same register in one cycle, the trap write wins. Generic writes to other registers in that cycle still take effect.
- o_mtvec, o_mstatus, o_mepc: direct register outputs, one-edge latency after any write; not gated by i_ren.
- Latency summary: read 0 cycles, write 1 edge.
- No handshake: the core is single-cycle and write enables are qualified upstream.
- X-safety: with all enables low, state holds indefinitely.

Optional Feature:
- Macro MSCRATCH_EN.
- Defined:
  - adds an mscratch register at 0x340, reset 0;
  - readable and writable via the generic ports only;
  - no trap port, and it does not appear on any direct output.
- Undefined:
  - 0x340 is unmapped: reads return 0 and writes are ignored.

Test Plan:
- Reset with i_rst=1 for 2 cycles, then release -> o_mstatus=0x00001800; o_mtvec=o_mepc=0; read of 0x342 with i_ren=1 returns 0.
- Generic write 0x305 <= 0x80000100, then read 0x305 -> o_rdata=0x80000100 and o_mtvec=0x80000100 after the edge; same-cycle read before the edge returns the old value 0.
- Trap writes: mepc_wen=1 with 0x80000010, mcause_wen=1 with 0x0000000B, mstatus_wen=1 with 0x00001880 -> next cycle o_mepc=0x80000010, mcause reads 0x0000000B, o_mstatus=0x00001880.
- Same-cycle conflict: i_wen=1 to 0x341 with 0xDEADBEEF, plus i_mepc_wen=1 with 0x80000020 -> o_mepc=0x80000020. Simultaneous generic write to 0x305 with 0x12345678 plus a trap mepc write -> both take effect.
- Unmapped and disabled reads: write 0x7C0 with 0xFFFFFFFF -> all CSRs unchanged. Read 0x7C0 -> 0. Read 0x300 with i_ren=0 -> 0.
- Reset mid-operation: i_rst=1 together with i_wen=1 to 0x305 -> mtvec=0 after the edge.
- MSCRATCH_EN builds: write 0x340 <= 0xA5A5A5A5 and read back equals 0xA5A5A5A5. Without the macro, the readback is 0.
